// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter that shares one buffered UART TX FIFO
// write port between NUM_CH byte-stream requesters, with optional channel-ID header.
module uart_tx_arbiter #(
  parameter int         NUM_CH  = 4,
  parameter bit         HDR_EN  = 1'b1,
  parameter logic [4:0] HDR_TAG = 5'h1A,
  parameter int         MAX_LEN = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   req_valid,
  input  logic [NUM_CH*8-1:0] req_data,
  input  logic [NUM_CH-1:0]   req_last,
  output logic [NUM_CH-1:0]   req_ready,
  output logic                tx_wr_en,
  output logic [7:0]          tx_wr_data,
  input  logic                tx_ready,
  output logic                grant_valid,
  output logic [2:0]          grant_id,
  output logic                len_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(MAX_LEN - 1);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [2:0]          rr_ptr_r;
  logic [2:0]          grant_id_r;
  logic                grant_valid_r;
  logic [7:0]          byte_cnt_r;
  logic                len_err_r;

  logic [2:0]          pick_s;
  logic                any_valid_s;
  logic                sel_valid_s;
  logic                sel_last_s;
  logic [7:0]          sel_data_s;
  logic                xfer_s;
  logic                at_max_s;
  logic                pkt_end_s;
  logic                cut_s;
  logic [2:0]          rr_next_s;
  logic [NUM_CH-1:0]   req_ready_s;
  logic                tx_wr_en_s;
  logic [7:0]          tx_wr_data_s;

  // Round-robin pick: descending offsets so the closest channel to rr_ptr wins.
  always_comb begin
    pick_s      = 3'd0;
    any_valid_s = |req_valid;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pick_s = ((i == (int'(rr_ptr_r) + k) % NUM_CH) && req_valid[i]) ? 3'(i) : pick_s;
      end
    end
  end

  // Mux the granted channel's stream signals.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = 8'h00;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_valid_s = (grant_id_r == 3'(i)) ? req_valid[i]       : sel_valid_s;
      sel_last_s  = (grant_id_r == 3'(i)) ? req_last[i]        : sel_last_s;
      sel_data_s  = (grant_id_r == 3'(i)) ? req_data[8*i +: 8] : sel_data_s;
    end
  end

  assign xfer_s    = (state_r == ST_DATA) & sel_valid_s & tx_ready;
  assign at_max_s  = (byte_cnt_r == LAST_CNT);
  assign pkt_end_s = xfer_s & (sel_last_s | at_max_s);
  assign cut_s     = xfer_s & ~sel_last_s & at_max_s;
  assign rr_next_s = (grant_id_r == 3'(NUM_CH - 1)) ? 3'd0 : grant_id_r + 3'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = any_valid_s ? (HDR_EN ? ST_HDR : ST_DATA) : ST_IDLE;
      ST_HDR:  state_nxt_s = tx_ready ? ST_DATA : ST_HDR;
      ST_DATA: state_nxt_s = pkt_end_s ? ST_IDLE : ST_DATA;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode; nothing reaches the FIFO or the requesters while in reset.
  always_comb begin
    tx_wr_en_s   = 1'b0;
    tx_wr_data_s = 8'h00;
    req_ready_s  = '0;
    case (state_r)
      ST_HDR: begin
        tx_wr_en_s   = tx_ready;
        tx_wr_data_s = {HDR_TAG, grant_id_r};
      end
      ST_DATA: begin
        tx_wr_en_s   = sel_valid_s & tx_ready;
        tx_wr_data_s = sel_data_s;
        for (int i = 0; i < NUM_CH; i++) begin
          req_ready_s[i] = (grant_id_r == 3'(i)) & tx_ready;
        end
      end
      default: begin
        tx_wr_en_s   = 1'b0;
        tx_wr_data_s = 8'h00;
        req_ready_s  = '0;
      end
    endcase
  end

  // Grant, round-robin pointer, payload counter and length-error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r      <= 3'd0;
      grant_id_r    <= 3'd0;
      grant_valid_r <= 1'b0;
      byte_cnt_r    <= 8'd0;
      len_err_r     <= 1'b0;
    end else begin
      len_err_r <= cut_s;
      if ((state_r == ST_IDLE) && any_valid_s) begin
        grant_id_r    <= pick_s;
        grant_valid_r <= 1'b1;
      end else if (pkt_end_s) begin
        grant_valid_r <= 1'b0;
        rr_ptr_r      <= rr_next_s;
        byte_cnt_r    <= 8'd0;
      end else if (xfer_s) begin
        byte_cnt_r    <= byte_cnt_r + 8'd1;
      end
    end
  end

  assign req_ready   = req_ready_s & {NUM_CH{rst_n}};
  assign tx_wr_en    = tx_wr_en_s & rst_n;
  assign tx_wr_data  = rst_n ? tx_wr_data_s : 8'h00;
  assign grant_valid = grant_valid_r;
  assign grant_id    = grant_id_r;
  assign len_err     = len_err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued requesters drive the DUT, a monitor
// compares every FIFO write and every new grant against hand-computed expectations.
module tb_uart_tx_arbiter;
  localparam int NCH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NCH-1:0]  req_valid = '0;
  logic [NCH*8-1:0] req_data = '0;
  logic [NCH-1:0]  req_last = '0;
  logic [NCH-1:0]  req_ready;
  logic            tx_wr_en;
  logic [7:0]      tx_wr_data;
  logic            tx_ready = 1'b1;
  logic            grant_valid;
  logic [2:0]      grant_id;
  logic            len_err;

  uart_tx_arbiter #(.NUM_CH(NCH), .HDR_EN(1'b1), .HDR_TAG(5'h1A), .MAX_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_wr_en(tx_wr_en),
    .tx_wr_data(tx_wr_data), .tx_ready(tx_ready), .grant_valid(grant_valid),
    .grant_id(grant_id), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [2:0] exp_g[$];
  logic [8:0] ch_q[NCH][$];
  int cyc = 0;
  int wr_cnt = 0;
  int len_err_cnt = 0;
  int wr_cyc[$];
  int rise_cyc[$];
  int fall_cyc[$];
  logic gv_prev = 1'b0;
  logic [NCH-1:0] acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input int ch, input logic [7:0] d, input logic last);
    ch_q[ch].push_back({last, d});
  endtask

  task automatic exp_pkt(input int ch);
    exp_g.push_back(3'(ch));
    exp_q.push_back(8'hD0 | 8'(ch));
  endtask

  function automatic logic busy();
    logic b = grant_valid;
    for (int i = 0; i < NCH; i++) b = b | (ch_q[i].size() > 0);
    return b | (exp_q.size() > 0) | (exp_g.size() > 0);
  endfunction

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy() && t < 300) begin
      tick();
      t++;
    end
    chk({name, "_drain"}, 32'(t < 300), 32'd1);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NCH; i++) ch_q[i].delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Requester model: pop a byte once it was accepted, then present the next one.
  initial forever begin
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (acc[i] && ch_q[i].size() > 0) void'(ch_q[i].pop_front());
      if (ch_q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_last[i] = ch_q[i][0][8];
        req_data[8*i +: 8] = ch_q[i][0][7:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i] = 1'b0;
      end
    end
  end

  // Monitor: every FIFO write and every new grant is scored against the queues.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (tx_wr_en) begin
      chk("wr_while_not_ready", 32'(tx_ready), 32'd1);
      if (exp_q.size() == 0) chk("unexpected_wr", {24'd0, tx_wr_data}, 32'hFFFF_FFFF);
      else chk("wr_data", {24'd0, tx_wr_data}, {24'd0, exp_q.pop_front()});
      wr_cnt++;
      wr_cyc.push_back(cyc);
    end
    if (grant_valid && !gv_prev) begin
      rise_cyc.push_back(cyc);
      if (exp_g.size() == 0) chk("unexpected_grant", {29'd0, grant_id}, 32'hFFFF_FFFF);
      else chk("grant_id", {29'd0, grant_id}, {29'd0, exp_g.pop_front()});
    end
    if (!grant_valid && gv_prev) fall_cyc.push_back(cyc);
    gv_prev = grant_valid;
    if (len_err) len_err_cnt++;
  end

  initial begin
    int base;
    int target;
    int t;
    int le0;
    logic pat[5];

    do_reset();
    @(negedge clk);
    chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    chk("rst_tx_wr_en", 32'(tx_wr_en), 32'd0);
    chk("rst_tx_wr_data", 32'(tx_wr_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    tick();

    // Single header+payload packet on consecutive cycles.
    base = wr_cyc.size();
    exp_pkt(2);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    req(2, 8'h11, 1'b0); req(2, 8'h22, 1'b0); req(2, 8'h33, 1'b1);
    wait_idle("t1");
    for (int k = 1; k <= 3; k++) chk("t1_consec", 32'(wr_cyc[base+k] - wr_cyc[base]), 32'(k));
    chk("t1_gv_drop", 32'(fall_cyc[fall_cyc.size()-1] - wr_cyc[base+3]), 32'd1);

    // Two contenders from reset, then rr_ptr=2 prefers ch2 over ch0.
    do_reset();
    exp_pkt(0); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_pkt(1); exp_q.push_back(8'h03); exp_q.push_back(8'h04);
    req(0, 8'h01, 1'b0); req(0, 8'h02, 1'b1);
    req(1, 8'h03, 1'b0); req(1, 8'h04, 1'b1);
    wait_idle("t2a");
    exp_pkt(2); exp_q.push_back(8'h06);
    exp_pkt(0); exp_q.push_back(8'h05);
    req(0, 8'h05, 1'b1); req(2, 8'h06, 1'b1);
    wait_idle("t2b");

    // All channels saturated with 1-byte packets.
    do_reset();
    base = rise_cyc.size();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NCH; i++) begin
        req(i, 8'(16*i + p), 1'b1);
        exp_pkt(i);
        exp_q.push_back(8'(16*i + p));
      end
    end
    wait_idle("t3");
    for (int k = 1; k < 8; k++) chk("t3_grant_spacing", 32'(rise_cyc[base+k] - rise_cyc[base+k-1]), 32'd3);

    // Backpressure during ch1 payload.
    target = wr_cnt + 1;
    exp_pkt(1);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
    req(1, 8'hA1, 1'b0); req(1, 8'hA2, 1'b0); req(1, 8'hA3, 1'b1);
    t = 0;
    while (wr_cnt < target && t < 50) begin tick(); t++; end
    chk("t4_hdr_seen", 32'(t < 50), 32'd1);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) begin
      tx_ready = pat[k];
      @(negedge clk);
      chk("t4_req_ready1", 32'(req_ready[1]), 32'(tx_ready));
      chk("t4_req_ready_others", 32'(req_ready & 4'b1101), 32'd0);
      tick();
    end
    tx_ready = 1'b1;
    wait_idle("t4");

    // Cut at MAX_LEN=4, remainder resent under a fresh header.
    le0 = len_err_cnt;
    exp_pkt(3);
    for (int k = 1; k <= 4; k++) exp_q.push_back(8'hB0 | 8'(k));
    exp_pkt(3);
    exp_q.push_back(8'hB5); exp_q.push_back(8'hB6);
    for (int k = 1; k <= 6; k++) req(3, 8'hB0 | 8'(k), 1'(k == 6));
    wait_idle("t5");
    chk("t5_len_err_pulses", 32'(len_err_cnt - le0), 32'd1);

    // Reset after the 2nd byte of a 5-byte ch2 packet, with rr_ptr=2 beforehand.
    exp_pkt(1); exp_q.push_back(8'hC0);
    exp_pkt(2); exp_q.push_back(8'hE1); exp_q.push_back(8'hE2);
    req(1, 8'hC0, 1'b1);
    for (int k = 1; k <= 5; k++) req(2, 8'hE0 | 8'(k), 1'(k == 5));
    target = wr_cnt + 5;
    t = 0;
    while (wr_cnt < target && t < 50) begin tick(); t++; end
    chk("t6_reach_byte2", 32'(t < 50), 32'd1);
    rst_n = 1'b0;
    ch_q[2].delete();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_grant_valid", 32'(grant_valid), 32'd0);
    chk("t6_tx_wr_en", 32'(tx_wr_en), 32'd0);
    tick();
    exp_pkt(0); exp_q.push_back(8'hF0);
    exp_pkt(3); exp_q.push_back(8'hF3);
    req(0, 8'hF0, 1'b1); req(3, 8'hF3, 1'b1);
    wait_idle("t6");

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("exp_g_empty", 32'(exp_g.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
